m_dm_pipe: RTL and testbench

Parametrised, multi-cycle data memory for the M stage. It replaces the single-cycle word/half/byte DM with these behaviours:
- a request/ready handshake with configurable access latency;
- little-endian byte-lane writes;
- sign- or zero-extended loads;
- alignment and range checking that raises AdEL/AdES instead of corrupting memory.

The M-stage stall logic holds the pipeline while `Busy` is high.

---
 rtl/m_dm_pipe_pkg.sv | 24 ++
 rtl/m_dm_lane.sv | 51 +++++
 rtl/m_dm_pipe.sv | 140 ++++++++++++++
 tb/tb_m_dm_pipe.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/m_dm_pipe_pkg.sv
// Shared encodings for the M-stage multi-cycle data memory: access widths,
// FSM states and the alignment rule.
package m_dm_pipe_pkg;

  localparam logic [1:0] type_w = 2'd0;
  localparam logic [1:0] type_h = 2'd1;
  localparam logic [1:0] type_b = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Reserved width encoding behaves as a word access.
  function automatic logic misaligned(input logic [1:0] dtype, input logic [1:0] off);
    case (dtype)
      type_h:  return off[0];
      type_b:  return 1'b0;
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/m_dm_lane.sv
// Byte-lane helper: with load=0 merges store data into the old word, with
// load=1 selects and extends the addressed byte/half of the read word.
module m_dm_lane
  import m_dm_pipe_pkg::*;
(
  input  logic        load,
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  dtype,
  input  logic [31:0] data,
  input  logic        sgn,
  output logic [31:0] res
);

  logic [31:0] merged;
  logic [31:0] loaded;
  logic [31:0] mask;
  logic [31:0] shdata;
  logic [7:0]  bsel;
  logic [15:0] hsel;

  always_comb begin
    mask   = 32'hffff_ffff;
    shdata = data;
    case (dtype)
      type_b: begin
        mask   = 32'h0000_00ff << {off, 3'b000};
        shdata = {24'd0, data[7:0]} << {off, 3'b000};
      end
      type_h: begin
        mask   = 32'h0000_ffff << {off[1], 4'b0000};
        shdata = {16'd0, data[15:0]} << {off[1], 4'b0000};
      end
      default: ;
    endcase
    merged = (word & ~mask) | (shdata & mask);
  end

  always_comb begin
    bsel = 8'(word >> {off, 3'b000});
    hsel = 16'(word >> {off[1], 4'b0000});
    case (dtype)
      type_b:  loaded = {{24{sgn & bsel[7]}}, bsel};
      type_h:  loaded = {{16{sgn & hsel[15]}}, hsel};
      default: loaded = word;
    endcase
  end

  assign res = load ? loaded : merged;

endmodule

// File: rtl/m_dm_pipe.sv
// M-stage data memory with req/ready handshake, configurable latency and
// AdEL/AdES checking. Define DM_TRACE_EN to print committed stores.
module m_dm_pipe
  import m_dm_pipe_pkg::*;
#(
  parameter int DEPTH   = 3072,
  parameter int AW      = 12,
  parameter int LATENCY = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        WE,
  input  logic [31:0] Addr,
  input  logic [31:0] Data,
  input  logic [1:0]  DataType,
  input  logic        Signed,
  input  logic [31:0] PC,
  output logic        Busy,
  output logic        Ready,
  output logic [31:0] Out,
  output logic        AdEL,
  output logic        AdES
);

  localparam logic [1:0]  CNT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;
  localparam logic [AW:0] DEPTH_W  = (AW + 1)'(DEPTH);

  state_e      state, nxt;
  logic [1:0]  cnt;

  logic        c_we, c_sgn;
  logic [31:0] c_addr, c_data, c_pc;
  logic [1:0]  c_dtype;

  logic        a_we, a_sgn;
  logic [31:0] a_addr, a_data, a_pc;
  logic [1:0]  a_dtype;

  logic [31:0] mem [DEPTH];

  logic          enter_done;
  logic [AW-1:0] idx;
  logic          in_range, fault;
  logic [31:0]   rd_word, merged, loaded;

  // With LATENCY=1 DONE is entered on the accepting edge, so the access
  // works from the live request rather than the capture registers.
  always_comb begin
    if (state == IDLE) begin
      a_we = WE; a_sgn = Signed; a_addr = Addr; a_data = Data; a_pc = PC; a_dtype = DataType;
    end else begin
      a_we = c_we; a_sgn = c_sgn; a_addr = c_addr; a_data = c_data; a_pc = c_pc; a_dtype = c_dtype;
    end
  end

  assign idx        = a_addr[AW+1:2];
  assign in_range   = ({1'b0, idx} < DEPTH_W) && ((a_addr >> (AW + 2)) == 32'd0);
  assign fault      = !in_range || misaligned(a_dtype, a_addr[1:0]);
  assign rd_word    = in_range ? mem[idx] : 32'd0;
  assign enter_done = (nxt == DONE) && (state != DONE);

  m_dm_lane u_st (
    .load(1'b0), .word(rd_word), .off(a_addr[1:0]), .dtype(a_dtype),
    .data(a_data), .sgn(a_sgn), .res(merged)
  );

  m_dm_lane u_ld (
    .load(1'b1), .word(rd_word), .off(a_addr[1:0]), .dtype(a_dtype),
    .data(a_data), .sgn(a_sgn), .res(loaded)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (Req) nxt = (LATENCY > 1) ? WAIT : DONE;
      WAIT: if (cnt == 2'd0) nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign Busy  = (state != IDLE);
  assign Ready = (state == DONE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt     <= 2'd0;
      c_we    <= 1'b0;
      c_sgn   <= 1'b0;
      c_addr  <= 32'd0;
      c_data  <= 32'd0;
      c_pc    <= 32'd0;
      c_dtype <= type_w;
      Out     <= 32'd0;
      AdEL    <= 1'b0;
      AdES    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else begin
      if (state == IDLE && Req) begin
        c_we    <= WE;
        c_sgn   <= Signed;
        c_addr  <= Addr;
        c_data  <= Data;
        c_pc    <= PC;
        c_dtype <= DataType;
        cnt     <= CNT_INIT;
      end else if (state == WAIT) begin
        cnt <= cnt - 2'd1;
      end

      if (enter_done) begin
        AdEL <= fault & ~a_we;
        AdES <= fault & a_we;
        Out  <= (fault || a_we) ? 32'd0 : loaded;
        if (a_we && !fault) begin
          mem[idx] <= merged;
`ifdef DM_TRACE_EN
          $display("%d@%h: *%h <= %h", $time, a_pc, {a_addr[31:2], 2'b00}, merged);
`endif
        end
      end else if (state == DONE) begin
        Out  <= 32'd0;
        AdEL <= 1'b0;
        AdES <= 1'b0;
      end
    end
  end

`ifndef DM_TRACE_EN
  logic unused_pc;
  assign unused_pc = ^a_pc;
`endif

endmodule

// File: tb/tb_m_dm_pipe.sv
// Directed bench for m_dm_pipe: one LATENCY=1 and one LATENCY=3 instance,
// expected results queued at request time and popped at Ready.
module tb_m_dm_pipe;
  import m_dm_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req1, req3;
  logic        we, sgn;
  logic [31:0] addr, data, pc;
  logic [1:0]  dt;

  logic        busy1, rdy1, adel1, ades1;
  logic        busy3, rdy3, adel3, ades3;
  logic [31:0] out1, out3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] out;
    bit          chk_out;
    logic        adel;
    logic        ades;
    int          lat;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  m_dm_pipe #(.DEPTH(3072), .AW(12), .LATENCY(1)) u_l1 (
    .Clk(clk), .Reset(rst), .Req(req1), .WE(we), .Addr(addr), .Data(data),
    .DataType(dt), .Signed(sgn), .PC(pc), .Busy(busy1), .Ready(rdy1),
    .Out(out1), .AdEL(adel1), .AdES(ades1)
  );

  m_dm_pipe #(.DEPTH(3072), .AW(12), .LATENCY(3)) u_l3 (
    .Clk(clk), .Reset(rst), .Req(req3), .WE(we), .Addr(addr), .Data(data),
    .DataType(dt), .Signed(sgn), .PC(pc), .Busy(busy3), .Ready(rdy3),
    .Out(out3), .AdEL(adel3), .AdES(ades3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic access(input bit l3, input string tag, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] t, input bit s,
                        input bit chk_out, input logic [31:0] eout,
                        input logic eadel, input logic eades);
    exp_t e;
    int   n;
    bit   got;
    e.tag = tag; e.out = eout; e.chk_out = chk_out;
    e.adel = eadel; e.ades = eades; e.lat = l3 ? 3 : 1;
    sbq.push_back(e);
    @(negedge clk);
    we = w; addr = a; data = d; dt = t; sgn = s; pc = pc + 32'd4;
    if (l3) req3 = 1'b1; else req1 = 1'b1;
    @(posedge clk);
    #1 req1 = 1'b0; req3 = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = l3 ? rdy3 : rdy1;
    end
    e = sbq.pop_front();
    chk({e.tag, ".lat"}, 64'(n), 64'(e.lat));
    if (got) begin
      chk({e.tag, ".adel"}, 64'(l3 ? adel3 : adel1), 64'(e.adel));
      chk({e.tag, ".ades"}, 64'(l3 ? ades3 : ades1), 64'(e.ades));
      if (e.chk_out) chk({e.tag, ".out"}, 64'(l3 ? out3 : out1), 64'(e.out));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rcnt, bcnt, perr;
    rst = 1'b1; req1 = 1'b0; req3 = 1'b0; we = 1'b0; sgn = 1'b0;
    addr = '0; data = '0; pc = 32'h0040_3000; dt = type_w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.l1", {29'd0, busy1, rdy1, adel1, ades1, out1}, 64'd0);
    chk("reset.l3", {29'd0, busy3, rdy3, adel3, ades3, out3}, 64'd0);
    rst = 1'b0;

    // LATENCY=1 instance
    access(0, "sw10",   1, 32'h10, 32'h1122_3344, type_w, 0, 0, 0, 0, 0);
    access(0, "sb11",   1, 32'h11, 32'h0000_008a, type_b, 0, 0, 0, 0, 0);
    access(0, "lw10",   0, 32'h10, 0, type_w, 0, 1, 32'h1122_8a44, 0, 0);
    access(0, "lb11",   0, 32'h11, 0, type_b, 1, 1, 32'hffff_ff8a, 0, 0);
    access(0, "lbu11",  0, 32'h11, 0, type_b, 0, 1, 32'h0000_008a, 0, 0);
    access(0, "lbu13",  0, 32'h13, 0, type_b, 1, 1, 32'h0000_0011, 0, 0);
    access(0, "sh22",   1, 32'h22, 32'h1234_beef, type_h, 0, 0, 0, 0, 0);
    access(0, "lw20",   0, 32'h20, 0, type_w, 0, 1, 32'hbeef_0000, 0, 0);
    access(0, "lh22",   0, 32'h22, 0, type_h, 1, 1, 32'hffff_beef, 0, 0);
    access(0, "lhu22",  0, 32'h22, 0, type_h, 0, 1, 32'h0000_beef, 0, 0);
    access(0, "sw12",   1, 32'h12, 32'hdead_dead, type_w, 0, 0, 0, 0, 1);
    access(0, "lw10b",  0, 32'h10, 0, type_w, 0, 1, 32'h1122_8a44, 0, 0);
    access(0, "lh13",   0, 32'h13, 0, type_h, 1, 1, 32'h0, 1, 0);
    access(0, "lres10", 0, 32'h10, 0, 2'd3,   1, 1, 32'h1122_8a44, 0, 0);
    access(0, "lw3000", 0, 32'h3000, 0, type_w, 0, 1, 32'h0, 1, 0);
    access(0, "sw3000", 1, 32'h3000, 32'h5555_5555, type_w, 0, 0, 0, 0, 1);
    access(0, "sw10000",1, 32'h1_0000, 32'h6666_6666, type_w, 0, 0, 0, 0, 1);
    access(0, "lw0",    0, 32'h0, 0, type_w, 0, 1, 32'h0, 0, 0);
    access(0, "sw2ffc", 1, 32'h2ffc, 32'hcafe_f00d, type_w, 0, 0, 0, 0, 0);
    access(0, "lw2ffc", 0, 32'h2ffc, 0, type_w, 0, 1, 32'hcafe_f00d, 0, 0);

    // LATENCY=3 instance
    access(1, "l3.sw44", 1, 32'h44, 32'h1234_5678, type_w, 0, 0, 0, 0, 0);
    access(1, "l3.lw44", 0, 32'h44, 0, type_w, 0, 1, 32'h1234_5678, 0, 0);

    // Req held high: accept, WAIT, WAIT, DONE, IDLE repeating
    @(negedge clk);
    we = 1'b0; addr = 32'h44; dt = type_w; req3 = 1'b1;
    rcnt = 0; bcnt = 0; perr = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      rcnt += int'(rdy3);
      bcnt += int'(busy3);
      if (rdy3 !== ((i % 4) == 3) || busy3 !== ((i % 4) != 0)) perr++;
    end
    req3 = 1'b0;
    chk("b2b.ready_cnt", 64'(rcnt), 64'd4);
    chk("b2b.busy_cnt",  64'(bcnt), 64'd12);
    chk("b2b.pattern",   64'(perr), 64'd0);

    // Reset in WAIT aborts the store and clears the array
    @(negedge clk);
    we = 1'b1; addr = 32'h40; data = 32'hdead_beef; dt = type_w; req3 = 1'b1;
    @(posedge clk);
    #1 req3 = 1'b0;
    @(negedge clk);
    chk("rst.in_wait", 64'(busy3), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst.outputs", {29'd0, busy3, rdy3, adel3, ades3, out3}, 64'd0);
    rst = 1'b0;
    rcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rcnt += int'(rdy3);
    end
    chk("rst.no_ready", 64'(rcnt), 64'd0);
    access(1, "l3.lw40", 0, 32'h40, 0, type_w, 0, 1, 32'h0, 0, 0);
    access(1, "l3.lw44z", 0, 32'h44, 0, type_w, 0, 1, 32'h0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
